// File: rtl/next_level_memory.sv
// next_level_memory
//
// Backing store that answers the cache's next-level port. It accepts one
// line-fill (read) or writeback (write) at a time and responds a fixed
// LATENCY cycles after acceptance. The store holds DEPTH lines. Each line
// has a valid bit, so a line that was never written reads back as zero.
//
// Handshake: a request is accepted only when `request` is high at a rising
// edge while the block is idle (busy == 0). `valid` pulses for exactly one
// cycle, LATENCY edges after acceptance, for both reads and writes. On a
// read, `rdata` is valid from that pulse onward and holds until the next
// read response. There is no backpressure and no queue. A request seen
// while busy is dropped and latches `overrun` until reset.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-low
//   request    one-cycle request strobe
//   write      1 = writeback, 0 = line fill (qualifies request)
//   addr       byte address; line index = addr[OFFSETBITS +: INDEXBITS]
//   wdata      writeback line, sampled with request
//   rdata      registered fill data
//   valid      one-cycle response strobe
//   busy       high while a request is outstanding
//   overrun    sticky: request presented while busy
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESPOND)
module next_level_memory #(
  parameter int ADDRBITS  = 32,
  parameter int WORDBITS  = 32,
  parameter int LINEITEMS = 64,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            request,
  input  logic                            write,
  input  logic [ADDRBITS-1:0]             addr,
  input  logic [LINEITEMS*WORDBITS-1:0]   wdata,
  output logic [LINEITEMS*WORDBITS-1:0]   rdata,
  output logic                            valid,
  output logic                            busy,
  output logic                            overrun,
  output logic [1:0]                      dbg_state
);

  localparam int LINEW      = LINEITEMS * WORDBITS;
  localparam int INDEXBITS  = $clog2(DEPTH);
  localparam int OFFSETBITS = $clog2(LINEITEMS * WORDBITS / 8);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   accept;
  logic                   commit;
  logic [7:0]             cnt;
  logic                   write_q;
  logic [INDEXBITS-1:0]   idx_q;
  logic [LINEW-1:0]       wdata_q;
  logic [LINEW-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]       lv;

  // Offset and upper address bits carry no meaning here; upper-bit aliasing
  // is intended.
  logic unused_addr;
  assign unused_addr = ^addr;

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 8'd0) begin
          commit     = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy      = (state != IDLE);
    valid     = (state == RESPOND);
    dbg_state = state;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Request capture, latency counter, fill data, line-valid bits and the
  // sticky overrun flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt     <= 8'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      lv      <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= write;
        idx_q   <= addr[OFFSETBITS +: INDEXBITS];
        wdata_q <= wdata;
        cnt     <= CNT_LOAD;
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end

      if (commit) begin
        if (write_q) lv[idx_q] <= 1'b1;
        else         rdata     <= lv[idx_q] ? mem[idx_q] : '0;
      end

      if (request && state != IDLE) overrun <= 1'b1;
    end
  end

  // Line storage has no reset. Stale contents stay hidden behind lv. The
  // reset term keeps a write from landing on the same edge that discards it.
  always_ff @(posedge clock) begin
    if (reset && commit && write_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_next_level_memory.sv
module tb_next_level_memory;

  localparam int AW    = 32;
  localparam int WB    = 32;
  localparam int LI    = 16;   // 64-byte lines: byte offset is addr[5:0]
  localparam int DEPTH = 1024;
  localparam int LW    = LI * WB;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT a: LATENCY 4 ----------------
  logic          req_a = 1'b0, wr_a = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [LW-1:0] wdata_a = '0, rdata_a;
  logic          valid_a, busy_a, overrun_a;
  logic [1:0]    st_a;

  next_level_memory #(.ADDRBITS(AW), .WORDBITS(WB), .LINEITEMS(LI),
                      .DEPTH(DEPTH), .LATENCY(4)) dut_a (
    .clock(clock), .reset(reset), .request(req_a), .write(wr_a),
    .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .valid(valid_a),
    .busy(busy_a), .overrun(overrun_a), .dbg_state(st_a));

  // ---------------- DUT b: LATENCY 1 ----------------
  logic          req_b = 1'b0, wr_b = 1'b0;
  logic [AW-1:0] addr_b = '0;
  logic [LW-1:0] wdata_b = '0, rdata_b;
  logic          valid_b, busy_b, overrun_b;
  logic [1:0]    st_b;

  next_level_memory #(.ADDRBITS(AW), .WORDBITS(WB), .LINEITEMS(LI),
                      .DEPTH(DEPTH), .LATENCY(1)) dut_b (
    .clock(clock), .reset(reset), .request(req_b), .write(wr_b),
    .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .valid(valid_b),
    .busy(busy_b), .overrun(overrun_b), .dbg_state(st_b));

  // ---------------- scoreboard ----------------
  logic [LW-1:0] exp_q_a[$];
  int            cyc_q_a[$];
  logic [LW-1:0] exp_q_b[$];
  int            cyc_q_b[$];

  // Reference model: written lines per index, plus last read data.
  logic [LW-1:0] mem_a[int];
  logic [LW-1:0] mem_b[int];
  logic [LW-1:0] last_a = '0;
  logic [LW-1:0] last_b = '0;

  task automatic check(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a >> 6) & 32'h3FF);
  endfunction

  // Monitor: every valid pulse must match the oldest expected response,
  // both in data and in the cycle it appears.
  always @(negedge clock) begin
    if (valid_a) begin
      if (exp_q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL valid_a_unexpected: got valid at cycle %0d want none", cyc);
      end else begin
        check("rdata_a", rdata_a, exp_q_a.pop_front());
        check("valid_a_cycle", LW'(cyc), LW'(cyc_q_a.pop_front()));
      end
    end
    if (valid_b) begin
      if (exp_q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL valid_b_unexpected: got valid at cycle %0d want none", cyc);
      end else begin
        check("rdata_b", rdata_b, exp_q_b.pop_front());
        check("valid_b_cycle", LW'(cyc), LW'(cyc_q_b.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  // Drive a one-cycle request. The acceptance edge E0 is the next rising
  // edge; returns 1ns after E0. With push=1 the expected response is queued.
  task automatic send_a(input logic w, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, input bit push);
    @(posedge clock); #1;
    req_a = 1'b1; wr_a = w; addr_a = a; wdata_a = d;
    if (push) begin
      if (w) mem_a[idx_of(a)] = d;
      else   last_a = mem_a.exists(idx_of(a)) ? mem_a[idx_of(a)] : '0;
      exp_q_a.push_back(last_a);
      cyc_q_a.push_back(cyc + 1 + 4);
    end
    @(posedge clock); #1;
    req_a = 1'b0; wr_a = 1'b0;
  endtask

  task automatic send_b(input logic w, input logic [AW-1:0] a,
                        input logic [LW-1:0] d);
    @(posedge clock); #1;
    req_b = 1'b1; wr_b = w; addr_b = a; wdata_b = d;
    if (w) mem_b[idx_of(a)] = d;
    else   last_b = mem_b.exists(idx_of(a)) ? mem_b[idx_of(a)] : '0;
    exp_q_b.push_back(last_b);
    cyc_q_b.push_back(cyc + 1 + 1);
    @(posedge clock); #1;
    req_b = 1'b0; wr_b = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [LW-1:0] beef, p3, p7, d1, d2, ones;
  int busy_cnt;

  initial begin
    beef = {LI{32'hDEAD_BEEF}};
    p3   = {LI{32'hA5A5_0003}};
    p7   = {LI{32'h7777_0007}};
    d1   = {LI{32'h0102_0304}};
    d2   = {LI{32'hCAFE_0009}};
    ones = '1;

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("reset_rdata", rdata_a, '0);
    check("reset_valid", LW'(valid_a), '0);
    check("reset_busy", LW'(busy_a), '0);
    check("reset_overrun", LW'(overrun_a), '0);
    check("reset_state", LW'(st_a), '0);

    // Read index 1 from a fresh store: zero data, busy for 5 cycles.
    send_a(1'b0, 32'h0000_0040, '0, 1);
    busy_cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (busy_a) busy_cnt++;
    end
    check("busy_cycles", LW'(busy_cnt), LW'(5));

    // Write then read index 5. The write response keeps rdata at 0.
    send_a(1'b1, 32'h0000_0140, beef, 1);
    repeat (5) @(posedge clock);
    send_a(1'b0, 32'h0000_0140, '0, 1);
    repeat (5) @(posedge clock);
    check("raw_idx5", rdata_a, beef);

    // Write index 3, read it back through an aliased address.
    send_a(1'b1, 32'h0000_00C0, p3, 1);
    repeat (5) @(posedge clock);
    send_a(1'b0, 32'h0010_00C0, '0, 1);
    repeat (5) @(posedge clock);
    check("alias_idx3", rdata_a, p3);

    // Overrun: a second request 2 cycles after acceptance is dropped.
    send_a(1'b0, 32'h0000_0140, '0, 1);
    @(posedge clock); #1;
    req_a = 1'b1; wr_a = 1'b1; addr_a = 32'h0000_01C0; wdata_a = ones;
    @(posedge clock); #1;
    req_a = 1'b0; wr_a = 1'b0;
    @(negedge clock);
    check("overrun_set", LW'(overrun_a), LW'(1));
    repeat (4) @(posedge clock);
    // The dropped write must not have reached index 7.
    send_a(1'b0, 32'h0000_01C0, '0, 1);
    repeat (5) @(posedge clock);
    check("overrun_sticky", LW'(overrun_a), LW'(1));

    // Reset two cycles into a write to index 7: no response, store cleared.
    send_a(1'b1, 32'h0000_01C0, p7, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    mem_a.delete();
    last_a = '0;
    @(negedge clock);
    check("midreset_busy", LW'(busy_a), '0);
    check("midreset_overrun", LW'(overrun_a), '0);
    check("midreset_rdata", rdata_a, '0);
    repeat (6) @(posedge clock);
    send_a(1'b0, 32'h0000_01C0, '0, 1);
    repeat (5) @(posedge clock);
    send_a(1'b0, 32'h0000_0140, '0, 1);
    repeat (5) @(posedge clock);
    check("cleared_idx5", rdata_a, '0);

    // Reset and request on the same edge: the request is not accepted.
    @(posedge clock); #1;
    reset = 1'b0; req_a = 1'b1; addr_a = 32'h0000_0040;
    @(posedge clock); #1;
    reset = 1'b1; req_a = 1'b0;
    @(negedge clock);
    check("reset_wins_busy", LW'(busy_a), '0);
    repeat (6) @(posedge clock);

    // LATENCY 1: requests accepted every 3 cycles.
    send_b(1'b1, 32'h0000_0080, d1); @(posedge clock);
    send_b(1'b0, 32'h0000_0080, '0); @(posedge clock);
    send_b(1'b0, 32'h0000_0240, '0); @(posedge clock);
    send_b(1'b1, 32'h0000_0240, d2); @(posedge clock);
    send_b(1'b0, 32'h0000_0240, '0); @(posedge clock);
    send_b(1'b0, 32'h0000_0080, '0);
    repeat (4) @(posedge clock);
    check("lat1_last", rdata_b, d1);
    check("lat1_overrun", LW'(overrun_b), '0);

    @(negedge clock);
    check("pending_a", LW'(exp_q_a.size()), '0);
    check("pending_b", LW'(exp_q_b.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
